// File: rtl/inert_seq.sv
// inert_seq: power-up configuration and yaw-rate read sequencer
// that sits in front of the inertial sensor's SPI monarch.
module inert_seq #(
    parameter int unsigned INIT_WAIT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        init_done
);

    localparam logic [2:0] PWR_WT = 3'd0;
    localparam logic [2:0] CFG    = 3'd1;
    localparam logic [2:0] WT_INT = 3'd2;
    localparam logic [2:0] RD_L   = 3'd3;
    localparam logic [2:0] RD_H   = 3'd4;

    localparam logic [15:0] CMD_INT = 16'h0D02;
    localparam logic [15:0] CMD_ACC = 16'h1062;
    localparam logic [15:0] CMD_GYR = 16'h1162;
    localparam logic [15:0] CMD_RND = 16'h1460;
    localparam logic [15:0] CMD_YL  = 16'hA600;
    localparam logic [15:0] CMD_YH  = 16'hA700;

    localparam logic [15:0] CNT_LAST = 16'(INIT_WAIT - 1);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [1:0]  r_cfg_idx;
    logic        r_done_q;
    logic        r_int_s1;
    logic        r_int_s2;
    logic [7:0]  r_yaw_lo;
    logic        r_wrt;
    logic [15:0] r_cmd;
    logic [15:0] r_yaw_rt;
    logic        r_vld;
    logic        r_init_done;

    logic        w_cmplt;
    logic [1:0]  w_idx_nxt;
    logic [15:0] w_cfg_cmd;

    // done_q resets high so a done held across reset is not a completion
    assign w_cmplt   = done & ~r_done_q;
    assign w_idx_nxt = r_cfg_idx + 2'd1;

    always_comb begin
        case (w_idx_nxt)
            2'd1:    w_cfg_cmd = CMD_ACC;
            2'd2:    w_cfg_cmd = CMD_GYR;
            2'd3:    w_cfg_cmd = CMD_RND;
            default: w_cfg_cmd = CMD_INT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_s1 <= 1'b0;
            r_int_s2 <= 1'b0;
            r_done_q <= 1'b1;
        end else begin
            r_int_s1 <= INT;
            r_int_s2 <= r_int_s1;
            r_done_q <= done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PWR_WT;
            r_cnt       <= 16'h0000;
            r_cfg_idx   <= 2'd0;
            r_yaw_lo    <= 8'h00;
            r_wrt       <= 1'b0;
            r_cmd       <= 16'h0000;
            r_yaw_rt    <= 16'h0000;
            r_vld       <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_wrt <= 1'b0;
            r_vld <= 1'b0;
            case (r_state)
                PWR_WT: begin
                    if (r_cnt != 16'hFFFF)
                        r_cnt <= r_cnt + 16'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_wrt     <= 1'b1;
                        r_cmd     <= CMD_INT;
                        r_cfg_idx <= 2'd0;
                        r_state   <= CFG;
                    end
                end
                CFG: begin
                    if (w_cmplt) begin
                        if (r_cfg_idx != 2'd3) begin
                            r_cfg_idx <= w_idx_nxt;
                            r_wrt     <= 1'b1;
                            r_cmd     <= w_cfg_cmd;
                        end else begin
                            r_init_done <= 1'b1;
                            r_state     <= WT_INT;
                        end
                    end
                end
                WT_INT: begin
                    if (r_int_s2) begin
                        r_wrt   <= 1'b1;
                        r_cmd   <= CMD_YL;
                        r_state <= RD_L;
                    end
                end
                RD_L: begin
                    if (w_cmplt) begin
                        r_yaw_lo <= rd_data[7:0];
                        r_wrt    <= 1'b1;
                        r_cmd    <= CMD_YH;
                        r_state  <= RD_H;
                    end
                end
                RD_H: begin
                    if (w_cmplt) begin
                        r_yaw_rt <= {rd_data[7:0], r_yaw_lo};
                        r_vld    <= 1'b1;
                        r_state  <= WT_INT;
                    end
                end
                default: r_state <= PWR_WT;
            endcase
        end
    end

    assign wrt       = r_wrt;
    assign cmd       = r_cmd;
    assign yaw_rt    = r_yaw_rt;
    assign vld       = r_vld;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_inert_seq.sv
// Scoreboard bench for inert_seq: directed stimulus with a small
// SPI monarch model; a monitor checks every wrt/vld pulse in order.
module tb_inert_seq;

    typedef struct {
        bit          is_vld;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] yaw_rt;
    logic        vld;
    logic        init_done;

    exp_t        exp_q[$];
    logic [15:0] rsp_q[$];
    int          cyc;
    int          n_vec = 0;
    int          n_err = 0;
    int          lat = 300;
    bit          model_en = 1'b1;

    inert_seq #(.INIT_WAIT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .INT       (INT),
        .done      (done),
        .rd_data   (rd_data),
        .wrt       (wrt),
        .cmd       (cmd),
        .yaw_rt    (yaw_rt),
        .vld       (vld),
        .init_done (init_done)
    );

    always #10 clk = ~clk;

    // cyc = number of clk edges since the last reset release
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expw(logic [15:0] v, int c);
        exp_t e;
        e.is_vld = 1'b0; e.val = v; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic expv(logic [15:0] v, int c);
        exp_t e;
        e.is_vld = 1'b1; e.val = v; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(bit k, logic [15:0] v);
        exp_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got kind=%0d val=%h cyc=%0d, required no pulse",
                     k, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_vld != k || e.val !== v || e.cyc != cyc) begin
                n_err++;
                $display("FAIL sb_pulse: got kind=%0d val=%h cyc=%0d, required kind=%0d val=%h cyc=%0d",
                         k, v, cyc, e.is_vld, e.val, e.cyc);
            end
        end
    endtask

    // monitor
    initial forever begin
        @(negedge clk);
        if (wrt === 1'b1) pop_chk(1'b0, cmd);
        if (vld === 1'b1) pop_chk(1'b1, yaw_rt);
    end

    // SPI monarch model: drops done on wrt, raises it lat edges later
    initial begin : model
        int          cnt;
        bit          pend;
        logic [15:0] nxt;
        cnt = 0; pend = 1'b0; nxt = 16'h0;
        done = 1'b1; rd_data = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                pend = 1'b0;
                done = 1'b1;
            end else if (model_en && wrt === 1'b1) begin
                done = 1'b0; pend = 1'b1; cnt = lat;
                nxt = 16'hEEEE;
                if (cmd[15] && rsp_q.size() != 0) nxt = rsp_q.pop_front();
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    done = 1'b1; rd_data = nxt; pend = 1'b0;
                end
            end
        end
    end

    task automatic run_to(int c);
        int g;
        g = 0;
        while (cyc < c && g < 20000) begin
            @(negedge clk); g++;
        end
        if (cyc < c) chk("timeout", cyc, c);
    endtask

    task automatic powerup(int L);
        int s;
        s = L + 1;
        expw(16'h0D02, 16);
        expw(16'h1062, 16 + s);
        expw(16'h1162, 16 + 2 * s);
        expw(16'h1460, 16 + 3 * s);
        run_to(16 + 4 * s - 1);
        chk("init_early", init_done, 0);
        run_to(16 + 4 * s);
        chk("init_rise", init_done, 1);
        run_to(16 + 4 * s + 30);
        chk("drain_cfg", exp_q.size(), 0);
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        chk("rst_wrt", wrt, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_yaw", yaw_rt, 0);
        chk("rst_vld", vld, 0);
        chk("rst_init", init_done, 0);
        rst_n = 1'b1;
        powerup(300);

        // single read, INT glitch during RD_H must not add a read
        lat = 5;
        c = cyc;
        rsp_q.push_back(16'hAB34);
        rsp_q.push_back(16'hCD12);
        expw(16'hA600, c + 3);
        expw(16'hA700, c + 9);
        expv(16'h1234, c + 15);
        INT = 1'b1;
        run_to(c + 3);
        INT = 1'b0;
        run_to(c + 9);
        INT = 1'b1;
        run_to(c + 11);
        INT = 1'b0;
        run_to(c + 40);
        chk("drain_rd1", exp_q.size(), 0);
        chk("yaw_1234", yaw_rt, 16'h1234);

        // INT held through vld: back-to-back reads, high bits ignored
        c = cyc;
        rsp_q.push_back(16'h0056);
        rsp_q.push_back(16'h0078);
        rsp_q.push_back(16'hABF0);
        rsp_q.push_back(16'hABFF);
        expw(16'hA600, c + 3);
        expw(16'hA700, c + 9);
        expv(16'h7856, c + 15);
        expw(16'hA600, c + 16);
        expw(16'hA700, c + 22);
        expv(16'hFFF0, c + 28);
        INT = 1'b1;
        run_to(c + 16);
        INT = 1'b0;
        run_to(c + 50);
        chk("drain_rd2", exp_q.size(), 0);
        chk("yaw_fff0", yaw_rt, 16'hFFF0);

        // reset in RD_L
        c = cyc;
        rsp_q.push_back(16'h0011);
        expw(16'hA600, c + 3);
        INT = 1'b1;
        run_to(c + 3);
        INT = 1'b0;
        run_to(c + 5);
        rst_n = 1'b0;
        #1;
        chk("mid_wrt", wrt, 0);
        chk("mid_vld", vld, 0);
        chk("mid_init", init_done, 0);
        chk("mid_yaw", yaw_rt, 0);
        chk("mid_cmd", cmd, 0);
        chk("mid_drain", exp_q.size(), 0);
        exp_q.delete();
        rsp_q.delete();
        repeat (3) @(negedge clk);
        lat = 20;
        rst_n = 1'b1;
        powerup(20);

        // stale done: held high, never rises
        rst_n = 1'b0;
        model_en = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expw(16'h0D02, 16);
        run_to(400);
        chk("stale_init", init_done, 0);
        chk("stale_cmd", cmd, 16'h0D02);
        chk("drain_stale", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
